roulette_game_ctrl: RTL and testbench
=====================================

# roulette_game_ctrl

Game controller that drives the 8-LED roulette spinner from the initiating side of the spin handshake. It accepts a player bet and a start-button press and charges the stake. It then issues the single-cycle `start_spin` request, waits for the spinner's `spin_done`/`result_pos` reply, judges win or lose, updates a credit balance, and holds the outcome for display. It sits between the debounced board inputs and the spinner; its outputs feed the spinner and the credit/score display logic.

## Interface
- `INIT_CREDITS`, default 10: credit balance after reset and after game-over restart.
- `BET_COST`, default 1: credits charged per spin.
- `WIN_PAYOUT`, default 8: credits added on a correct guess.
- `CREDIT_W`, default 8: width of the credit counter.
- `RESULT_HOLD`, default 25_000_000: cycles that win/lose stays asserted (0.5 s at 50 MHz).
- `SPIN_TIMEOUT`, default 50_000_000: cycles to wait for `spin_done` (used only with the macro).
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `btn_start`, in, 1: debounced start button, level. The block detects the rising edge internally.
- `bet_sel`, in, 3: guessed position 0–7. Sampled only on an accepted press.
- `spin_done`, in, 1: one-cycle completion pulse from the spinner.
- `result_pos`, in, 3: spinner stop position. Valid in the same cycle as `spin_done`.
- `start_spin`, out, 1: one-cycle spin request to the spinner.
- `busy`, out, 1: high from the accepted press until the judge cycle.
- `win`, out, 1: high for the hold window when `result_pos == bet`.
- `lose`, out, 1: high for the hold window when `result_pos != bet`.
- `game_over`, out, 1: high while credits are below `BET_COST`.
- `credits`, out, `CREDIT_W`: current balance.
- `last_result`, out, 3: last accepted `result_pos`.
- `bet_latched`, out, 3: bet of the current or last spin.
- `timeout_err`, out, 1: sticky spin-timeout flag. Present only with the macro.

## Operation
- The state machine has six states: IDLE, LAUNCH, WAIT_SPIN, JUDGE, SHOW, OVER.
- **IDLE:**
  - Waits for a `btn_start` rising edge (current sample 1, previous registered sample 0) while `credits >= BET_COST`.
  - On that edge: `bet_latched <= bet_sel`, `credits <= credits - BET_COST`, go to LAUNCH.
  - Presses made while credits are insufficient are ignored.
- **LAUNCH:** `start_spin` is high for this one cycle only. Go to WAIT_SPIN.
- **WAIT_SPIN:** On `spin_done`, set `last_result <= result_pos` and go to JUDGE.
- **JUDGE (one cycle):**
  - On a match: `credits <= min(credits + WIN_PAYOUT, 2^CREDIT_W - 1)` (saturating) and set `win`.
  - Otherwise set `lose`.
  - Go to SHOW.
- **SHOW:**
  - `win`/`lose` stay held while a counter runs through `RESULT_HOLD` cycles.
  - Then clear `win`/`lose`. Go to OVER if `credits < BET_COST`, else IDLE.
- **OVER:**
  - `game_over` is high.
  - A `btn_start` rising edge sets `credits <= INIT_CREDITS`, clears `game_over`, and returns to IDLE.
- **Ignored inputs:**
  - `btn_start` edges outside IDLE and OVER are ignored, but the edge detector keeps tracking the button level.
  - `spin_done` outside WAIT_SPIN is ignored.
- **Arithmetic:** all credit arithmetic is unsigned `CREDIT_W` bits. Subtraction happens only when guarded by the `>=` check, so it never underflows.

## Timing
- **Reset values:**
  - `credits` = `INIT_CREDITS`; all other outputs 0.
  - State = IDLE; edge-detector register = 0; timers = 0.
- **Reset mid-operation:** reset in any state returns to the reset values immediately. `start_spin` must never glitch high while `rst` is active.
- **Press to request:**
  - An accepting edge at clock N makes `credits` update and `start_spin` go high during cycle N+1.
  - `start_spin` is low again from N+2.
- **Spin completion:** `spin_done` sampled high at edge M makes `last_result` valid from M+1 (JUDGE). `win`/`lose` and the payout are visible from M+2.
- **Hold window:** `win`/`lose` are high for exactly `RESULT_HOLD` cycles. The following state is entered on the next edge.
- **`busy`:** high from cycle N+1 through the JUDGE cycle inclusive.
- All outputs are registered.

## Configuration
- Macro: `ROULETTE_SPIN_TIMEOUT_EN`.
- **Defined:**
  - WAIT_SPIN counts cycles. If `spin_done` has not arrived after `SPIN_TIMEOUT` cycles, refund `BET_COST` (saturating), set `timeout_err` (sticky until reset), and return to IDLE.
  - If `spin_done` and the timeout coincide, `spin_done` wins and no refund is made.
- **Undefined:** WAIT_SPIN waits indefinitely. The `timeout_err` port and the counter are absent.

## Structure
- **Package `roulette_pkg`:**
  - State enum.
  - Default values for `INIT_CREDITS`, `BET_COST`, `WIN_PAYOUT`, `RESULT_HOLD`, `SPIN_TIMEOUT`.
  - Position width constant `POS_W = 3`.
- **Sub-module `roulette_cycle_timer`:**
  - Loadable down-counter with a `done` flag.
  - Shared by the SHOW hold and the WAIT_SPIN timeout, since the two never run at once.
- Edge detect, credit arithmetic and the state machine live in the top module.

## Test plan
Bench parameters: `INIT_CREDITS=2`, `BET_COST=1`, `WIN_PAYOUT=8`, `RESULT_HOLD=4`, `SPIN_TIMEOUT=16`.
- **Win:** `bet_sel=5`, press, reply `spin_done` with `result_pos=5` → one `start_spin` pulse, `credits` 2→1→9, `win` high for 4 cycles.
- **Lose to game over:** two losing spins (bet 3, result 6) → `credits` 2→1→0, `lose` pulses twice, `game_over=1`. A further press → `credits=2`, IDLE.
- **Ignored events:** pressing during WAIT_SPIN and a stray `spin_done` in IDLE → no extra `start_spin`, no credit change.
- **Saturation:** with `credits=250` forced via a bench path of wins on `CREDIT_W=8`, a win → `credits=255`, not a wrap.
- **Timeout (macro on):** no `spin_done` for 16 cycles → `credits` restored, `timeout_err=1`, IDLE. With the macro off → still WAIT_SPIN.
- **Reset mid-spin:** `rst` asserted in WAIT_SPIN → `credits=2`, all flags 0, `start_spin=0`. The next press launches normally.

Source files
------------

// File: rtl/roulette_pkg.sv
// Shared types and default constants for the roulette game controller.
package roulette_pkg;

    localparam int unsigned POS_W            = 3;
    localparam int unsigned DEF_CREDIT_W     = 8;
    localparam int unsigned DEF_INIT_CREDITS = 10;
    localparam int unsigned DEF_BET_COST     = 1;
    localparam int unsigned DEF_WIN_PAYOUT   = 8;
    localparam int unsigned DEF_RESULT_HOLD  = 25_000_000;
    localparam int unsigned DEF_SPIN_TIMEOUT = 50_000_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_SPIN = 3'd2,
        ST_JUDGE     = 3'd3,
        ST_SHOW      = 3'd4,
        ST_OVER      = 3'd5
    } state_e;

endpackage

// File: rtl/roulette_game_ctrl_cycle_timer.sv
// Loadable down-counter; done_c is high while the count sits at zero.
// A load of N makes done_c rise after N further clock edges.
module roulette_cycle_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins, otherwise decrement until zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_c = (count_q == '0);

endmodule

// File: rtl/roulette_game_ctrl.sv
// Roulette game controller: takes a bet and start press, charges the stake,
// requests a spin, judges the spinner's reply and keeps the credit balance.
// Optional spin timeout with refund is enabled by ROULETTE_SPIN_TIMEOUT_EN.
module roulette_game_ctrl
    import roulette_pkg::*;
#(
    parameter int unsigned INIT_CREDITS = DEF_INIT_CREDITS,
    parameter int unsigned BET_COST     = DEF_BET_COST,
    parameter int unsigned WIN_PAYOUT   = DEF_WIN_PAYOUT,
    parameter int unsigned CREDIT_W     = DEF_CREDIT_W,
    parameter int unsigned RESULT_HOLD  = DEF_RESULT_HOLD,
    parameter int unsigned SPIN_TIMEOUT = DEF_SPIN_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_start,
    input  logic [POS_W-1:0]    bet_sel,
    input  logic                spin_done,
    input  logic [POS_W-1:0]    result_pos,
    output logic                start_spin,
    output logic                busy,
    output logic                win,
    output logic                lose,
    output logic                game_over,
    output logic [CREDIT_W-1:0] credits,
    output logic [POS_W-1:0]    last_result,
    output logic [POS_W-1:0]    bet_latched
`ifdef ROULETTE_SPIN_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    // One timer serves both the result hold and the spin timeout.
    localparam int unsigned TMR_MAX = (RESULT_HOLD > SPIN_TIMEOUT) ? RESULT_HOLD : SPIN_TIMEOUT;
    localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0] HOLD_LOAD =
        TMR_W'((RESULT_HOLD == 0) ? 0 : RESULT_HOLD - 1);
`ifdef ROULETTE_SPIN_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TOUT_LOAD =
        TMR_W'((SPIN_TIMEOUT == 0) ? 0 : SPIN_TIMEOUT - 1);
`endif

    localparam logic [CREDIT_W-1:0] INIT_C = CREDIT_W'(INIT_CREDITS);
    localparam logic [CREDIT_W-1:0] BET_C  = CREDIT_W'(BET_COST);
    localparam logic [CREDIT_W-1:0] PAY_C  = CREDIT_W'(WIN_PAYOUT);

    // Unsigned add clamped at the all-ones credit value.
    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                    input logic [CREDIT_W-1:0] b);
        logic [CREDIT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
    endfunction

    state_e              state_q, state_d;
    logic                btn_q, btn_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic [POS_W-1:0]    bet_latched_q, bet_latched_d;
    logic [POS_W-1:0]    last_result_q, last_result_d;
    logic                start_spin_q, start_spin_d;
    logic                busy_q, busy_d;
    logic                win_q, win_d;
    logic                lose_q, lose_d;
    logic                game_over_q, game_over_d;
`ifdef ROULETTE_SPIN_TIMEOUT_EN
    logic                timeout_err_q, timeout_err_d;
`endif

    logic                rise_c;
    logic                tmr_load_c;
    logic [TMR_W-1:0]    tmr_val_c;
    logic                tmr_done_c;

    roulette_cycle_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .done_c   (tmr_done_c)
    );

    assign rise_c = btn_start & ~btn_q;

    // Next-state, credit arithmetic and registered output values.
    always_comb begin
        state_d        = state_q;
        btn_d          = btn_start;
        credits_d      = credits_q;
        bet_latched_d  = bet_latched_q;
        last_result_d  = last_result_q;
        win_d          = win_q;
        lose_d         = lose_q;
        tmr_load_c     = 1'b0;
        tmr_val_c      = '0;
`ifdef ROULETTE_SPIN_TIMEOUT_EN
        timeout_err_d  = timeout_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rise_c && (credits_q >= BET_C)) begin
                    bet_latched_d = bet_sel;
                    credits_d     = credits_q - BET_C;
                    state_d       = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_SPIN;
`ifdef ROULETTE_SPIN_TIMEOUT_EN
                tmr_load_c = 1'b1;
                tmr_val_c  = TOUT_LOAD;
`endif
            end
            ST_WAIT_SPIN: begin
                if (spin_done) begin
                    last_result_d = result_pos;
                    state_d       = ST_JUDGE;
                end
`ifdef ROULETTE_SPIN_TIMEOUT_EN
                else if (tmr_done_c) begin
                    credits_d     = sat_add(credits_q, BET_C);
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end
`endif
            end
            ST_JUDGE: begin
                if (last_result_q == bet_latched_q) begin
                    credits_d = sat_add(credits_q, PAY_C);
                    win_d     = 1'b1;
                end else begin
                    lose_d    = 1'b1;
                end
                tmr_load_c = 1'b1;
                tmr_val_c  = HOLD_LOAD;
                state_d    = ST_SHOW;
            end
            ST_SHOW: begin
                if (tmr_done_c) begin
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    state_d = (credits_q < BET_C) ? ST_OVER : ST_IDLE;
                end
            end
            ST_OVER: begin
                if (rise_c) begin
                    credits_d = INIT_C;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        start_spin_d = (state_d == ST_LAUNCH);
        busy_d       = (state_d == ST_LAUNCH) || (state_d == ST_WAIT_SPIN) || (state_d == ST_JUDGE);
        game_over_d  = (state_d == ST_OVER);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            btn_q         <= 1'b0;
            credits_q     <= INIT_C;
            bet_latched_q <= '0;
            last_result_q <= '0;
            start_spin_q  <= 1'b0;
            busy_q        <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            game_over_q   <= 1'b0;
`ifdef ROULETTE_SPIN_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            btn_q         <= btn_d;
            credits_q     <= credits_d;
            bet_latched_q <= bet_latched_d;
            last_result_q <= last_result_d;
            start_spin_q  <= start_spin_d;
            busy_q        <= busy_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
            game_over_q   <= game_over_d;
`ifdef ROULETTE_SPIN_TIMEOUT_EN
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign start_spin  = start_spin_q;
    assign busy        = busy_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign game_over   = game_over_q;
    assign credits     = credits_q;
    assign last_result = last_result_q;
    assign bet_latched = bet_latched_q;
`ifdef ROULETTE_SPIN_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_roulette_game_ctrl.sv
// Bench for roulette_game_ctrl: table of spins plus hand-written corner cases,
// with a result scoreboard popped when win/lose rises.
module tb_roulette_game_ctrl;

    localparam int unsigned INIT_CR = 2;
    localparam int unsigned BET     = 1;
    localparam int unsigned PAY     = 8;
    localparam int unsigned HOLD    = 4;
    localparam int unsigned TOUT    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic [2:0] bet_sel = 3'd0;
    logic       spin_done = 1'b0;
    logic [2:0] result_pos = 3'd0;
    logic       start_spin, busy, win, lose, game_over;
    logic [7:0] credits;
    logic [2:0] last_result, bet_latched;
`ifdef ROULETTE_SPIN_TIMEOUT_EN
    logic       timeout_err;
`endif

    roulette_game_ctrl #(
        .INIT_CREDITS (INIT_CR),
        .BET_COST     (BET),
        .WIN_PAYOUT   (PAY),
        .CREDIT_W     (8),
        .RESULT_HOLD  (HOLD),
        .SPIN_TIMEOUT (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_start   (btn_start),
        .bet_sel     (bet_sel),
        .spin_done   (spin_done),
        .result_pos  (result_pos),
        .start_spin  (start_spin),
        .busy        (busy),
        .win         (win),
        .lose        (lose),
        .game_over   (game_over),
        .credits     (credits),
        .last_result (last_result),
        .bet_latched (bet_latched)
`ifdef ROULETTE_SPIN_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic w;
        logic [7:0] cr;
    } sb_t;

    typedef struct {
        logic [2:0] bet;
        logic [2:0] res;
        bit         extra;
        logic       exp_w;
        logic [7:0] exp_cr;
    } vec_t;

    sb_t         sb_q[$];
    vec_t        vecs[6];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned exp_cr = INIT_CR;
    logic [2:0]  exp_last = 3'd0;
    int unsigned spin_cnt = 0;
    int unsigned hold_cnt = 0;
    logic        prev_wl = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned sat8(input int unsigned x);
        return (x > 255) ? 255 : x;
    endfunction

    // Scoreboard monitor: pops on win/lose rise, checks hold length on fall.
    always @(negedge clk) begin
        if (rst) begin
            prev_wl  = 1'b0;
            hold_cnt = 0;
        end else begin
            if (start_spin) spin_cnt++;
            if ((win || lose) && !prev_wl) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: win=%0d lose=%0d with no pending spin at %0t", win, lose, $time);
                end else begin
                    sb_t it;
                    it = sb_q.pop_front();
                    check("sb_win", 32'(win), 32'(it.w));
                    check("sb_lose", 32'(lose), 32'(!it.w));
                    check("sb_credits", 32'(credits), 32'(it.cr));
                end
            end
            if (win || lose) begin
                hold_cnt++;
            end else if (prev_wl) begin
                check("hold_len", hold_cnt, HOLD);
                hold_cnt = 0;
            end
            prev_wl = win | lose;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; btn_start = 1'b0; spin_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        exp_cr   = INIT_CR;
        exp_last = 3'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || win || lose) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL wait_idle: still busy after %0d cycles", n);
        end
    endtask

    task automatic press_accept(input logic [2:0] b);
        @(posedge clk); #1;
        bet_sel = b; btn_start = 1'b1;
        @(posedge clk); #1;
        btn_start = 1'b0;
        exp_cr = exp_cr - BET;
        check("launch_pulse", 32'(start_spin), 1);
        check("charge", 32'(credits), exp_cr);
        check("bet_latched", 32'(bet_latched), 32'(b));
        check("busy_launch", 32'(busy), 1);
        @(posedge clk); #1;
        check("launch_end", 32'(start_spin), 0);
    endtask

    task automatic reply(input logic [2:0] b, input logic [2:0] r, input bit extra);
        sb_t it;
        if (extra) begin
            btn_start = 1'b1;
            @(posedge clk); #1;
            btn_start = 1'b0;
            @(posedge clk); #1;
        end
        it.w  = (b == r);
        it.cr = it.w ? 8'(sat8(exp_cr + PAY)) : 8'(exp_cr);
        exp_cr = it.cr;
        sb_q.push_back(it);
        result_pos = r; spin_done = 1'b1;
        @(posedge clk); #1;
        spin_done = 1'b0;
        exp_last  = r;
        check("last_result", 32'(last_result), 32'(r));
        check("busy_judge", 32'(busy), 1);
        wait_idle();
        check("credits_after", 32'(credits), exp_cr);
    endtask

    task automatic run_spin(input logic [2:0] b, input logic [2:0] r, input bit extra);
        int unsigned cnt0;
        cnt0 = spin_cnt;
        press_accept(b);
        reply(b, r, extra);
        check("spin_count", spin_cnt, cnt0 + 1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned cnt0;
        vecs[0] = '{bet: 3'd5, res: 3'd5, extra: 1'b0, exp_w: 1'b1, exp_cr: 8'd9};
        vecs[1] = '{bet: 3'd3, res: 3'd6, extra: 1'b0, exp_w: 1'b0, exp_cr: 8'd8};
        vecs[2] = '{bet: 3'd0, res: 3'd0, extra: 1'b1, exp_w: 1'b1, exp_cr: 8'd15};
        vecs[3] = '{bet: 3'd7, res: 3'd1, extra: 1'b0, exp_w: 1'b0, exp_cr: 8'd14};
        vecs[4] = '{bet: 3'd2, res: 3'd2, extra: 1'b0, exp_w: 1'b1, exp_cr: 8'd21};
        vecs[5] = '{bet: 3'd4, res: 3'd4, extra: 1'b1, exp_w: 1'b1, exp_cr: 8'd28};

        // Reset values
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_credits", 32'(credits), INIT_CR);
        check("rst_start_spin", 32'(start_spin), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_win", 32'(win), 0);
        check("rst_lose", 32'(lose), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_last_result", 32'(last_result), 0);
        check("rst_bet_latched", 32'(bet_latched), 0);

        // Stray spin_done in IDLE is ignored
        cnt0 = spin_cnt;
        @(posedge clk); #1;
        result_pos = 3'd3; spin_done = 1'b1;
        @(posedge clk); #1;
        spin_done = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("stray_credits", 32'(credits), exp_cr);
        check("stray_last", 32'(last_result), 32'(exp_last));
        check("stray_busy", 32'(busy), 0);
        check("stray_spin_cnt", spin_cnt, cnt0);

        // Table of spins, some with a press during WAIT_SPIN
        for (int i = 0; i < 6; i++) begin
            run_spin(vecs[i].bet, vecs[i].res, vecs[i].extra);
            check("vec_credits", 32'(credits), 32'(vecs[i].exp_cr));
            check("vec_outcome_model", 32'(vecs[i].exp_w), 32'(vecs[i].bet == vecs[i].res));
        end

        // Lose down to game over, then restart
        do_reset();
        run_spin(3'd3, 3'd6, 1'b0);
        run_spin(3'd3, 3'd6, 1'b0);
        check("over_flag", 32'(game_over), 1);
        check("over_credits", 32'(credits), 0);
        cnt0 = spin_cnt;
        @(posedge clk); #1;
        btn_start = 1'b1;
        @(posedge clk); #1;
        btn_start = 1'b0;
        exp_cr = INIT_CR;
        check("restart_credits", 32'(credits), INIT_CR);
        check("restart_game_over", 32'(game_over), 0);
        check("restart_start_spin", 32'(start_spin), 0);
        check("restart_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("restart_no_spin", spin_cnt, cnt0);
        run_spin(3'd1, 3'd2, 1'b0);

        // Saturation: reach 250 then win
        do_reset();
        for (int i = 0; i < 36; i++) run_spin(3'(i), 3'(i), 1'b0);
        for (int i = 0; i < 4; i++) run_spin(3'd0, 3'd1, 1'b0);
        check("sat_pre", 32'(credits), 250);
        run_spin(3'd5, 3'd5, 1'b0);
        check("sat_clamp", 32'(credits), 255);

        // Spin timeout
        do_reset();
        press_accept(3'd1);
        repeat (30) @(posedge clk);
        #1;
`ifdef ROULETTE_SPIN_TIMEOUT_EN
        exp_cr = exp_cr + BET;
        check("tout_err", 32'(timeout_err), 1);
        check("tout_refund", 32'(credits), exp_cr);
        check("tout_idle", 32'(busy), 0);
`else
        check("tout_still_wait", 32'(busy), 1);
        check("tout_credits", 32'(credits), exp_cr);
        check("tout_no_spin", 32'(start_spin), 0);
`endif

        // Reset mid-spin
        do_reset();
        press_accept(3'd6);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_credits", 32'(credits), INIT_CR);
        check("mid_rst_start_spin", 32'(start_spin), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_win_lose", 32'(win | lose), 0);
        check("mid_rst_game_over", 32'(game_over), 0);
        check("mid_rst_bet", 32'(bet_latched), 0);
`ifdef ROULETTE_SPIN_TIMEOUT_EN
        check("mid_rst_tout", 32'(timeout_err), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        exp_cr = INIT_CR;
        exp_last = 3'd0;
        run_spin(3'd6, 3'd6, 1'b0);
        check("post_rst_credits", 32'(credits), 9);

        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
